// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Purpose : Core fetch/data ports, shared RAM port and MMIO outputs of the
//           memory port arbiter, bundled with master/slave views.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int unsigned MEM_IDX_W = 14
);
  logic                 i_req;
  logic [31:0]          i_addr;
  logic                 i_ack;
  logic                 i_rvalid;
  logic [31:0]          i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [31:0]          d_addr;
  logic [31:0]          d_wdata;
  logic                 d_ack;
  logic                 d_rvalid;
  logic [31:0]          d_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [MEM_IDX_W-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  logic                 sig_valid;
  logic [31:0]          sig_data;
  logic                 halted;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output sig_valid, sig_data, halted
  );

  // Core plus memory model side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  sig_valid, sig_data, halted
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Round-robin sharing of one single-port synchronous RAM between
//           instruction-fetch and data ports, plus signature/halt MMIO decode.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned MEM_IDX_W  = 14,
  parameter logic [31:0] SIG_ADDR   = 32'hF0000004,
  parameter logic [31:0] HALT_ADDR  = 32'hF0000000,
  parameter logic [31:0] HALT_MAGIC = 32'hCAFECAFE
) (
  input  wire logic          sysclk,
  input  wire logic          rst_in,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_e      state_q,      state_d;
  logic        last_grant_q, last_grant_d;
  logic        cmd_port_q,   cmd_port_d;
  logic        cmd_we_q,     cmd_we_d;
  logic [31:0] cmd_addr_q,   cmd_addr_d;
  logic [31:0] cmd_wdata_q,  cmd_wdata_d;
  logic        halted_q,     halted_d;
  logic [31:0] i_rdata_q,    i_rdata_d;
  logic [31:0] d_rdata_q,    d_rdata_d;

  logic        cmd_mmio;
  logic [31:0] rd_word;
  logic        grant;

  assign cmd_mmio = (cmd_addr_q[31:28] == 4'hF);
  assign rd_word  = cmd_mmio ? 32'h0 : bus.mem_rdata;

  // With both ports requesting, the port that did not win last time goes next.
  assign grant = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_port_d   = cmd_port_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    halted_d     = halted_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    bus.i_ack     = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = i_rdata_q;
    bus.d_ack     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = d_rdata_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    bus.sig_valid = 1'b0;
    bus.sig_data  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (!halted_q && (bus.i_req || bus.d_req)) begin
          cmd_port_d   = grant;
          cmd_we_d     = (grant == PORT_D) && bus.d_we;
          cmd_addr_d   = (grant == PORT_D) ? bus.d_addr  : bus.i_addr;
          cmd_wdata_d  = (grant == PORT_D) ? bus.d_wdata : 32'h0;
          last_grant_d = grant;
          state_d      = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        bus.i_ack = (cmd_port_q == PORT_I);
        bus.d_ack = (cmd_port_q == PORT_D);
        if (!cmd_mmio) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = cmd_we_q;
          bus.mem_addr  = cmd_addr_q[MEM_IDX_W+1:2];
          bus.mem_wdata = cmd_wdata_q;
        end else if (cmd_we_q) begin
          if (cmd_addr_q == SIG_ADDR) begin
            bus.sig_valid = 1'b1;
            bus.sig_data  = cmd_wdata_q;
          end
          if ((cmd_addr_q == HALT_ADDR) && (cmd_wdata_q == HALT_MAGIC)) begin
            halted_d = 1'b1;
          end
        end
        state_d = cmd_we_q ? ST_IDLE : ST_RDWAIT;
      end

      ST_RDWAIT: begin
        if (cmd_port_q == PORT_I) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = rd_word;
          i_rdata_d    = rd_word;
        end else begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = rd_word;
          d_rdata_d    = rd_word;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A reset cycle suppresses every strobe so an in-flight read never completes.
    if (rst_in) begin
      bus.i_ack     = 1'b0;
      bus.i_rvalid  = 1'b0;
      bus.i_rdata   = 32'h0;
      bus.d_ack     = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.d_rdata   = 32'h0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 32'h0;
      bus.sig_valid = 1'b0;
      bus.sig_data  = 32'h0;
    end
  end

  assign bus.halted = halted_q;

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      cmd_port_q   <= PORT_I;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 32'h0;
      cmd_wdata_q  <= 32'h0;
      halted_q     <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_port_q   <= cmd_port_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      halted_q     <= halted_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter with a word RAM model
//           and per-port scoreboards of expected read data.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  localparam int unsigned IDX = 14;

  logic sysclk = 1'b0;
  logic rst_in = 1'b1;
  always #5 sysclk = ~sysclk;

  mem_port_arbiter_if #(.MEM_IDX_W(IDX)) bus ();

  mem_port_arbiter #(
    .MEM_IDX_W (IDX),
    .SIG_ADDR  (32'hF0000004),
    .HALT_ADDR (32'hF0000000),
    .HALT_MAGIC(32'hCAFECAFE)
  ) dut (
    .sysclk(sysclk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  logic [31:0] mem [0:(1<<IDX)-1];
  logic [31:0] mem_rdata_r = 32'h0;

  always @(posedge sysclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_r       <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_r;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] i_q [$];
  logic [31:0] d_q [$];
  bit          model_last = 1'b1;   // 1 = data port won last

  task automatic wait_ack(input bit dport, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sysclk);
      if (dport ? bus.d_ack : bus.i_ack) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if ({bus.i_ack, bus.i_rvalid, bus.i_rdata, bus.d_ack, bus.d_rvalid, bus.d_rdata,
         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.sig_valid,
         bus.sig_data, bus.halted} !== '0)
      $display("FAIL reset_outputs_in_reset: outputs not all zero");
    else n_pass++;
    rst_in = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if ({bus.i_ack, bus.i_rvalid, bus.i_rdata, bus.d_ack, bus.d_rvalid, bus.d_rdata,
         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.sig_valid,
         bus.sig_data, bus.halted} !== '0)
      $display("FAIL reset_outputs_after: outputs not all zero");
    else n_pass++;
    model_last = 1'b1;
  endtask

  task automatic test_fetch;
    logic [31:0] exp;
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    i_q.push_back(32'h00500093);
    @(negedge sysclk);
    n_checks++;
    if ({bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we} !== 4'b1010)
      $display("FAIL fetch_ack: got ack/dack/en/we=%b expected 1010",
               {bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 14'd4) $display("FAIL fetch_mem_addr: got %0d expected 4", bus.mem_addr);
    else n_pass++;
    bus.i_req  = 1'b0;
    model_last = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (bus.i_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b expected 1", bus.i_rvalid);
    else n_pass++;
    exp = i_q.pop_front();
    n_checks++;
    if (bus.i_rdata !== exp) $display("FAIL fetch_rdata: got %h expected %h", bus.i_rdata, exp);
    else n_pass++;
    @(negedge sysclk);
    n_checks++;
    if ({bus.i_rvalid, bus.i_rdata} !== {1'b0, exp})
      $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 %h", bus.i_rvalid, bus.i_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_contention;
    int          ni = 0;
    int          nd = 0;
    bit          exp_port;
    bit          got;
    logic [31:0] exp;
    exp_port   = ~model_last;
    bus.i_addr = 32'h200 << 2;
    bus.i_req  = 1'b1;
    i_q.push_back(32'hA0000000);
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h300 << 2;
    bus.d_req  = 1'b1;
    d_q.push_back(32'hB0000000);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (ni == 4 && nd == 4 && i_q.size() == 0 && d_q.size() == 0) break;
      @(negedge sysclk);
      n_checks++;
      if ((bus.i_ack && bus.d_ack) || (bus.i_rvalid && bus.d_rvalid))
        $display("FAIL contention_overlap: i/d strobes coincide at cycle %0d", cyc);
      else n_pass++;
      if (bus.i_ack || bus.d_ack) begin
        got = bus.d_ack;
        n_checks++;
        if (got !== exp_port) $display("FAIL contention_order: got port %0d expected %0d", got, exp_port);
        else n_pass++;
        model_last = got;
        exp_port   = ~got;
        if (!got) begin
          ni++;
          if (ni < 4) begin
            bus.i_addr = (32'h200 + 32'(ni)) << 2;
            i_q.push_back(32'hA0000000 + 32'(ni));
          end else bus.i_req = 1'b0;
        end else begin
          nd++;
          if (nd < 4) begin
            bus.d_addr = (32'h300 + 32'(nd)) << 2;
            d_q.push_back(32'hB0000000 + 32'(nd));
          end else bus.d_req = 1'b0;
        end
      end
      if (bus.i_rvalid) begin
        exp = (i_q.size() != 0) ? i_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (bus.i_rdata !== exp) $display("FAIL contention_irdata: got %h expected %h", bus.i_rdata, exp);
        else n_pass++;
      end
      if (bus.d_rvalid) begin
        exp = (d_q.size() != 0) ? d_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (bus.d_rdata !== exp) $display("FAIL contention_drdata: got %h expected %h", bus.d_rdata, exp);
        else n_pass++;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    n_checks++;
    if (ni != 4 || nd != 4 || i_q.size() != 0 || d_q.size() != 0)
      $display("FAIL contention_done: got ni=%0d nd=%0d expected 4 4 with empty queues", ni, nd);
    else n_pass++;
  endtask

  task automatic test_write_read;
    bit          ok;
    logic [31:0] exp;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_req   = 1'b1;
    wait_ack(1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL wr_ack: got no d_ack expected one");
    else n_pass++;
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 14'h40, 32'hDEADBEEF})
      $display("FAIL wr_mem: got en=%b we=%b addr=%h wdata=%h expected 1 1 0040 deadbeef",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    model_last = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if (bus.d_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", bus.d_rvalid);
    else n_pass++;
    bus.d_req = 1'b1;
    d_q.push_back(32'hDEADBEEF);
    wait_ack(1'b1, ok);
    bus.d_req = 1'b0;
    @(negedge sysclk);
    exp = d_q.pop_front();
    n_checks++;
    if ({ok, bus.d_rvalid, bus.d_rdata} !== {2'b11, exp})
      $display("FAIL rd_back: got ack=%b rvalid=%b rdata=%h expected 1 1 %h", ok, bus.d_rvalid, bus.d_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_mmio;
    bit          ok;
    logic [31:0] exp;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'hF0000004;
    bus.d_wdata = 32'h12345678;
    bus.d_req   = 1'b1;
    wait_ack(1'b1, ok);
    n_checks++;
    if ({ok, bus.sig_valid, bus.sig_data, bus.mem_en} !== {2'b11, 32'h12345678, 1'b0})
      $display("FAIL sig_write: got ack=%b valid=%b data=%h en=%b expected 1 1 12345678 0",
               ok, bus.sig_valid, bus.sig_data, bus.mem_en);
    else n_pass++;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (bus.sig_valid !== 1'b0) $display("FAIL sig_pulse: got %b expected 0", bus.sig_valid);
    else n_pass++;
    bus.d_addr = 32'hF0000008;
    bus.d_req  = 1'b1;
    d_q.push_back(32'h0);
    wait_ack(1'b1, ok);
    n_checks++;
    if ({ok, bus.mem_en} !== 2'b10) $display("FAIL mmio_rd_ack: got ack=%b en=%b expected 1 0", ok, bus.mem_en);
    else n_pass++;
    bus.d_req = 1'b0;
    @(negedge sysclk);
    exp = d_q.pop_front();
    n_checks++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, exp})
      $display("FAIL mmio_rd_data: got rvalid=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_halt;
    bit ok;
    int acks = 0;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'hF0000000;
    bus.d_wdata = 32'h00000001;
    bus.d_req   = 1'b1;
    wait_ack(1'b1, ok);
    bus.d_req = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if ({ok, bus.halted} !== 2'b10) $display("FAIL halt_wrong_data: got ack=%b halted=%b expected 1 0", ok, bus.halted);
    else n_pass++;
    bus.d_wdata = 32'hCAFECAFE;
    bus.d_req   = 1'b1;
    wait_ack(1'b1, ok);
    n_checks++;
    if ({ok, bus.halted} !== 2'b10) $display("FAIL halt_timing: got ack=%b halted=%b expected 1 0", ok, bus.halted);
    else n_pass++;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if (bus.halted !== 1'b1) $display("FAIL halt_set: got %b expected 1", bus.halted);
    else n_pass++;
    repeat (12) begin
      @(negedge sysclk);
      if (bus.i_ack || bus.d_ack || bus.mem_en) acks++;
    end
    n_checks++;
    if (acks != 0 || bus.halted !== 1'b1)
      $display("FAIL halt_no_grant: got %0d grants halted=%b expected 0 1", acks, bus.halted);
    else n_pass++;
    bus.i_req = 1'b0;
  endtask

  task automatic test_reset_rdwait;
    bit          ok;
    logic [31:0] exp;
    rst_in = 1'b1;
    @(negedge sysclk);
    rst_in     = 1'b0;
    model_last = 1'b1;
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if ({bus.i_ack, bus.halted} !== 2'b10) $display("FAIL rst_rd_ack: got ack=%b halted=%b expected 1 0", bus.i_ack, bus.halted);
    else n_pass++;
    bus.i_req = 1'b0;
    @(negedge sysclk);
    rst_in = 1'b1;
    #1;
    n_checks++;
    if (bus.i_rvalid !== 1'b0) $display("FAIL rst_rvalid_dropped: got %b expected 0", bus.i_rvalid);
    else n_pass++;
    @(negedge sysclk);
    rst_in = 1'b0;
    #1;
    n_checks++;
    if ({bus.i_ack, bus.i_rvalid, bus.i_rdata, bus.d_ack, bus.d_rvalid, bus.d_rdata,
         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.sig_valid,
         bus.sig_data, bus.halted} !== '0)
      $display("FAIL rst_outputs: outputs not all zero, i_rdata=%h i_rvalid=%b", bus.i_rdata, bus.i_rvalid);
    else n_pass++;
    @(negedge sysclk);
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    i_q.push_back(32'h00500093);
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h100;
    bus.d_req  = 1'b1;
    d_q.push_back(32'hDEADBEEF);
    @(negedge sysclk);
    n_checks++;
    if ({bus.i_ack, bus.d_ack} !== 2'b10) $display("FAIL rst_i_priority: got i/d ack=%b expected 10", {bus.i_ack, bus.d_ack});
    else n_pass++;
    bus.i_req = 1'b0;
    @(negedge sysclk);
    exp = i_q.pop_front();
    n_checks++;
    if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, exp})
      $display("FAIL rst_i_rdata: got rvalid=%b rdata=%h expected 1 %h", bus.i_rvalid, bus.i_rdata, exp);
    else n_pass++;
    wait_ack(1'b1, ok);
    bus.d_req = 1'b0;
    @(negedge sysclk);
    exp = d_q.pop_front();
    n_checks++;
    if ({ok, bus.d_rvalid, bus.d_rdata} !== {2'b11, exp})
      $display("FAIL rst_d_rdata: got ack=%b rvalid=%b rdata=%h expected 1 1 %h", ok, bus.d_rvalid, bus.d_rdata, exp);
    else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < (1 << IDX); a++) mem[a] = 32'h0;
    mem[4] = 32'h00500093;
    for (int k = 0; k < 4; k++) begin
      mem[32'h200 + k] = 32'hA0000000 + 32'(k);
      mem[32'h300 + k] = 32'hB0000000 + 32'(k);
    end
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    test_reset();
    test_fetch();
    test_contention();
    test_write_read();
    test_mmio();
    test_halt();
    test_reset_rdwait();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word RAM between the core's instruction-fetch port and data port.
- Decodes the simulation MMIO window: signature writes at 0xF0000004 and the halt word 0xCAFECAFE written to 0xF0000000.
- Sits between the core and the shared memory model, both in the testbench and in the FPGA top.
- Handles arbitration (round-robin), request/ack/rvalid handshakes and sequencing of the one-cycle-latency RAM read.

Parameters:
- MEM_IDX_W, 14: width of the RAM word index. The RAM holds 2^MEM_IDX_W words.
- SIG_ADDR, 32'hF0000004: signature MMIO address.
- HALT_ADDR, 32'hF0000000: halt MMIO address.
- HALT_MAGIC, 32'hCAFECAFE: data value that triggers halt.

Ports:
- sysclk  in  1  system clock. All logic is on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle pulse: fetch accepted.
- i_rvalid  out  1  one-cycle pulse: i_rdata is valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata is valid (reads only).
- d_rdata  out  32  read data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_IDX_W  word index, taken from addr[MEM_IDX_W+1:2].
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0.
- sig_valid  out  1  one-cycle pulse per signature write.
- sig_data  out  32  signature word.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; last_grant = DATA, so the instruction port wins the first tie; halted = 0.
- Reset is synchronous. Asserted mid-operation, it drops any in-flight read and no rvalid is issued for it.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE, winner selection:
  - Only one req asserted: that port wins.
  - Both asserted: the port not equal to last_grant wins.
  - Winner's command is registered; last_grant is updated; next state is ACCESS.
  - No req, or halted = 1: stay in IDLE.
- ACCESS, winner's ack pulses high this cycle.
  - RAM address (addr[31:28] != 4'hF):
    - mem_en = 1, mem_we = d_we (instruction port is always read), mem_addr and mem_wdata driven from the registered command.
    - Write: next state IDLE.
    - Read: next state RDWAIT.
  - MMIO address (addr[31:28] == 4'hF): mem_en = 0.
    - Write to SIG_ADDR: sig_valid = 1, sig_data = wdata.
    - Write to HALT_ADDR with data == HALT_MAGIC: halted is set starting the next cycle.
    - Write to HALT_ADDR with any other data: dropped.
    - Any other MMIO write: dropped.
    - MMIO read: next state RDWAIT, returns 0.
    - MMIO write: next state IDLE.
- RDWAIT: the winner's rvalid pulses and rdata = mem_rdata (0 for MMIO); rdata holds its value until the next rvalid on that port. Next state IDLE.
- Latency from req sampled in IDLE at cycle N:
  - ack at N+1.
  - Read rvalid at N+2.
  - Next arbitration at N+2 (write) or N+3 (read).
- Requester rules: must hold req, addr, we and wdata stable until ack. Must deassert req in the cycle after ack unless it issues a new request.
- Only one transaction is outstanding at a time. i_* and d_* outputs are never active in the same cycle.
- Halt is sticky until rst_in. After halted = 1, no new grants are made; a transaction already in ACCESS/RDWAIT completes normally.
- Low address bits [1:0] are ignored; byte-lane writes are out of scope.

Test Plan:
- Reset, then i_req=1 with i_addr=0x00000010 and mem[4]=0x00500093:
  - i_ack at cycle 1, mem_en=1 with mem_addr=4 at cycle 1.
  - i_rvalid=1 with i_rdata=0x00500093 at cycle 2.
- Contention: i_req and d_req held high continuously:
  - Grants alternate I, D, I, D.
  - Neither port waits more than one foreign transaction.
  - Acks never coincide.
- Data write then read back:
  - d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF gives mem_we=1 with mem_addr=0x40.
  - A following read of 0x100 returns d_rdata=0xDEADBEEF.
- Signature: write 0x12345678 to 0xF0000004 -> sig_valid pulse with sig_data=0x12345678, mem_en stays 0.
- Halt:
  - Write 0x00000001 to 0xF0000000 -> no halt.
  - Write 0xCAFECAFE to 0xF0000000 -> halted=1; pending i_req is never acked afterwards.
- Assert rst_in during RDWAIT -> no rvalid, all outputs 0 next cycle, next request serviced normally with I priority.
